comp_acc: RTL

//  Complex accumulator, directly downstream of the complex multiplier. Takes
//  the multiplier's {xr,yr} result stream over val-rdy and sums NACC

---
 rtl/comp_acc.sv | 108 ++++++++++
 1 files changed

// File: rtl/comp_acc.sv
// Complex frame accumulator: sums NACC consecutive {xr,yr} products into one
// {xa,ya} result with a sticky signed-overflow flag, val-rdy on both sides.
module comp_acc #(
    parameter int DWIDTH = 8,
    parameter int NACC   = 4,
    parameter int AWIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_rst,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [4*(DWIDTH+1)-1:0] in_data,
    output logic                    acc_val,
    input  logic                    acc_rdy,
    output logic [2*AWIDTH-1:0]     acc_data,
    output logic                    acc_ovf
);
    localparam int PW = 2*DWIDTH + 2;
    localparam int CW = (NACC > 1) ? $clog2(NACC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NACC - 1);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                   r_state, w_state_next;
    logic [CW-1:0]            r_cnt, w_cnt_next;
    logic                     r_ovf, w_ovf_next;
    logic [1:0][AWIDTH-1:0]   w_acc;
    logic [1:0]               w_add_ovf;
    logic                     w_in_xfer, w_out_xfer, w_first;

    assign in_rdy     = (r_state == ST_ACC);
    assign acc_val    = (r_state == ST_OUT);
    assign w_in_xfer  = in_val & in_rdy;
    assign w_out_xfer = acc_val & acc_rdy;
    assign w_first    = (r_cnt == '0);

    // Component 1 is x (upper half), component 0 is y (lower half).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [PW-1:0] w_prod;
            logic [AWIDTH-1:0]    w_ext, w_sum, r_acc;

            assign w_prod = in_data[gi*PW +: PW];
            assign w_ext  = AWIDTH'(w_prod);
            assign w_sum  = r_acc + w_ext;
            assign w_add_ovf[gi] = (r_acc[AWIDTH-1] == w_ext[AWIDTH-1]) &&
                                   (w_sum[AWIDTH-1] != r_acc[AWIDTH-1]);
            assign w_acc[gi] = r_acc;

            // First product of a frame overwrites, so no stale sum survives.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_acc <= '0;
                else if (sw_rst)
                    r_acc <= '0;
                else if (w_in_xfer)
                    r_acc <= w_first ? w_ext : w_sum;
            end
        end
    endgenerate

    assign acc_data = w_acc;
    assign acc_ovf  = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (sw_rst) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        case (r_state)
            ST_ACC: begin
                if (w_in_xfer) begin
                    w_ovf_next = w_first ? 1'b0 : (r_ovf | (|w_add_ovf));
                    if (r_cnt == LAST_CNT) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_OUT;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
            end
            ST_OUT: begin
                if (w_out_xfer)
                    w_state_next = ST_ACC;
            end
            default: w_state_next = ST_ACC;
        endcase
    end
endmodule
